// File: rtl/mem_arbiter.sv
// Purpose: shares one four-bank main memory between the I-cache and D-cache controllers, one burst at a time.
// Latency: grant is registered (1 cycle after req is sampled); rd/wr/addr/data pass through combinationally while granted.
// Backpressure: a requester without grant simply stalls; ownership only moves after every bank reports idle.
module mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int MAX_D_WINS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_mem_rd,
   input  logic              i_mem_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data_in,
   input  logic              d_req,
   input  logic              d_mem_rd,
   input  logic              d_mem_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_data_in,
   input  logic [3:0]        busy,
   output logic              i_gnt,
   output logic              d_gnt,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Ceiling for consecutive D wins while I waits; once reached, I wins the next tie.
   localparam logic [3:0] MAX_WINS = 4'(MAX_D_WINS);

   state_t     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       err_q, err_d;

   logic i_stb;
   logic d_stb;

   assign i_stb = i_mem_rd | i_mem_wr;
   assign d_stb = d_mem_rd | d_mem_wr;

   // State, starvation counter and error pulse; reset drops any grant immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         starve_q <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   // Next-state selection: D wins ties until I has been passed over MAX_D_WINS times.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         IDLE: begin
            if (i_req && d_req) begin
               if (starve_q >= MAX_WINS) begin
                  state_d  = GNT_I;
                  starve_d = 4'd0;
               end else begin
                  state_d  = GNT_D;
                  starve_d = starve_q + 4'd1;
               end
            end else if (i_req) begin
               state_d  = GNT_I;
               starve_d = 4'd0;
            end else if (d_req) begin
               // I is not waiting, so this win does not count against it.
               state_d = GNT_D;
            end
         end
         GNT_I: begin
            if (!i_req) begin
               state_d = DRAIN;
            end
         end
         GNT_D: begin
            if (!d_req) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Banks may still be finishing the last burst; hold off the next owner.
            if (busy == 4'b0000) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Protocol checks on the current owner and the waiting side; reported one cycle later.
   always_comb begin
      err_d = 1'b0;
      case (state_q)
         GNT_I: err_d = d_stb | (i_mem_rd & i_mem_wr) | (~i_req & i_stb);
         GNT_D: err_d = i_stb | (d_mem_rd & d_mem_wr) | (~d_req & d_stb);
         default: err_d = 1'b0;
      endcase
   end

   // Grants decode from state only; memory port follows the owner and is quiet otherwise.
   always_comb begin
      i_gnt       = 1'b0;
      d_gnt       = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_data_in = '0;
      case (state_q)
         GNT_I: begin
            i_gnt       = 1'b1;
            mem_rd      = i_mem_rd;
            mem_wr      = i_mem_wr;
            mem_addr    = i_addr;
            mem_data_in = i_data_in;
         end
         GNT_D: begin
            d_gnt       = 1'b1;
            mem_rd      = d_mem_rd;
            mem_wr      = d_mem_wr;
            mem_addr    = d_addr;
            mem_data_in = d_data_in;
         end
         default: begin
            i_gnt = 1'b0;
         end
      endcase
   end

   assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run against a behavioural owner/drain model.
// Inputs change 2 time units after each rising edge; outputs are sampled before the next edge.
// All waits are fixed cycle counts, so the run always terminates.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int MAXW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, i_mem_rd, i_mem_wr;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_data_in;
   logic          d_req, d_mem_rd, d_mem_wr;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_data_in;
   logic [3:0]    busy;
   logic          i_gnt, d_gnt, mem_rd, mem_wr, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns memory (0 none, 1 I, 2 D), whether a handoff is
   // still waiting for banks, how many times I has lost a tie, and the error
   // expected after the last edge (m_err_known is low when the rule is not pinned down).
   int m_owner;
   bit m_drain;
   int m_wins;
   bit m_err;
   bit m_err_known;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_WINS(MAXW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_addr(i_addr), .i_data_in(i_data_in),
      .d_req(d_req), .d_mem_rd(d_mem_rd), .d_mem_wr(d_mem_wr), .d_addr(d_addr), .d_data_in(d_data_in),
      .busy(busy),
      .i_gnt(i_gnt), .d_gnt(d_gnt), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .err(err)
   );

   task automatic model_reset();
      m_owner = 0; m_drain = 0; m_wins = 0; m_err = 0; m_err_known = 1;
   endtask

   // Applies one clock edge's worth of arbitration rules to the model.
   task automatic model_edge();
      bit istb, dstb;
      istb = i_mem_rd | i_mem_wr;
      dstb = d_mem_rd | d_mem_wr;
      m_err = 0;
      m_err_known = 1;
      if (m_owner == 1) m_err = dstb | (i_mem_rd & i_mem_wr) | (!i_req & istb);
      else if (m_owner == 2) m_err = istb | (d_mem_rd & d_mem_wr) | (!d_req & dstb);
      else m_err_known = !(istb | dstb);

      if ((m_owner == 1 && !i_req) || (m_owner == 2 && !d_req)) begin
         m_owner = 0; m_drain = 1;
      end else if (m_owner == 0 && m_drain) begin
         if (busy == 4'b0000) m_drain = 0;
      end else if (m_owner == 0) begin
         if (i_req && d_req) begin
            if (m_wins == MAXW) begin m_owner = 1; m_wins = 0; end
            else begin m_owner = 2; m_wins = m_wins + 1; end
         end else if (i_req) begin
            m_owner = 1; m_wins = 0;
         end else if (d_req) begin
            m_owner = 2;
         end
      end
   endtask

   task automatic clear_inputs();
      i_req = 0; i_mem_rd = 0; i_mem_wr = 0; i_addr = '0; i_data_in = '0;
      d_req = 0; d_mem_rd = 0; d_mem_wr = 0; d_addr = '0; d_data_in = '0;
      busy = 4'b0000;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      #2;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      @(posedge clk);
      #2;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      i_req = 1; i_mem_rd = 1; i_addr = 16'h1234; d_req = 1; d_mem_wr = 1; d_data_in = 16'h5678;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (i_gnt !== 1'b0) begin failures++; $display("FAIL reset_i_gnt: got %b expected 0", i_gnt); end
      checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL reset_d_gnt: got %b expected 0", d_gnt); end
      checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL reset_strobes: rd=%b wr=%b expected 0 0", mem_rd, mem_wr); end
      checks++; if (mem_addr !== '0 || mem_data_in !== '0) begin failures++; $display("FAIL reset_bus: addr=%h data=%h expected 0 0", mem_addr, mem_data_in); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
      rst = 0;
      clear_inputs();
      model_reset();
      tick();
   endtask

   task automatic test_lone_d();
      d_req = 1; d_mem_rd = 1; d_addr = 16'h0040; d_data_in = 16'h1111;
      #1;
      checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL lone_d_pre: d_gnt=%b expected 0", d_gnt); end
      tick();
      checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin failures++; $display("FAIL lone_d_gnt: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt); end
      checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin failures++; $display("FAIL lone_d_fwd: rd=%b addr=%h expected 1 0040", mem_rd, mem_addr); end
      repeat (4) tick();
      checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL lone_d_hold: d_gnt=%b expected 1", d_gnt); end
      d_req = 0; d_mem_rd = 0; busy = 4'b0010;
      tick();
      checks++; if (d_gnt !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== '0) begin failures++; $display("FAIL lone_d_drain: gnt=%b rd=%b addr=%h expected 0 0 0", d_gnt, mem_rd, mem_addr); end
      tick();
      busy = 4'b0000; d_req = 1;
      tick();
      checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL lone_d_drain_busy: d_gnt=%b expected 0", d_gnt); end
      tick();
      checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL lone_d_regrant: d_gnt=%b expected 1", d_gnt); end
      d_req = 0;
      tick(); tick();
   endtask

   task automatic test_simultaneous();
      i_req = 1; i_mem_rd = 1; i_addr = 16'hAAAA;
      d_req = 1; d_mem_wr = 1; d_addr = 16'h0100; d_data_in = 16'hBEEF;
      tick();
      checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin failures++; $display("FAIL simul_gnt: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt); end
      checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b1) begin failures++; $display("FAIL simul_strobe: rd=%b wr=%b expected 0 1", mem_rd, mem_wr); end
      checks++; if (mem_addr !== 16'h0100 || mem_data_in !== 16'hBEEF) begin failures++; $display("FAIL simul_bus: addr=%h data=%h expected 0100 beef", mem_addr, mem_data_in); end
      tick();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL simul_err: err=%b expected 1", err); end
      i_mem_rd = 0;
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL simul_err_clear: err=%b expected 0", err); end
      d_req = 0; d_mem_wr = 0;
      tick();
      checks++; if (d_gnt !== 1'b0 || i_gnt !== 1'b0) begin failures++; $display("FAIL simul_drain: d_gnt=%b i_gnt=%b expected 0 0", d_gnt, i_gnt); end
      tick(); tick();
      checks++; if (i_gnt !== 1'b1) begin failures++; $display("FAIL simul_i_next: i_gnt=%b expected 1", i_gnt); end
      i_req = 0;
      tick(); tick();
   endtask

   task automatic test_starvation();
      do_reset();
      i_req = 1; d_req = 1;
      for (int k = 0; k <= MAXW; k++) begin
         tick();
         if (k < MAXW) begin
            checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin failures++; $display("FAIL starve_d_win%0d: d_gnt=%b i_gnt=%b expected 1 0", k, d_gnt, i_gnt); end
            d_req = 0;
            tick();
            d_req = 1;
            tick();
         end else begin
            checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL starve_i_forced: i_gnt=%b d_gnt=%b expected 1 0", i_gnt, d_gnt); end
         end
      end
      i_req = 0;
      tick();
      i_req = 1;
      tick(); tick();
      checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin failures++; $display("FAIL starve_cleared: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt); end
      i_req = 0; d_req = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_handoff();
      do_reset();
      i_req = 1;
      tick();
      checks++; if (i_gnt !== 1'b1) begin failures++; $display("FAIL handoff_i: i_gnt=%b expected 1", i_gnt); end
      d_req = 1;
      tick();
      checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL handoff_no_preempt: i_gnt=%b d_gnt=%b expected 1 0", i_gnt, d_gnt); end
      i_req = 0; busy = 4'b0000;
      tick();
      checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++; $display("FAIL handoff_drain: i_gnt=%b d_gnt=%b expected 0 0", i_gnt, d_gnt); end
      tick();
      checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++; $display("FAIL handoff_idle: i_gnt=%b d_gnt=%b expected 0 0", i_gnt, d_gnt); end
      tick();
      checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin failures++; $display("FAIL handoff_d: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt); end
   endtask

   // Continues from the D grant left by test_handoff.
   task automatic test_proto_err();
      d_mem_rd = 1; d_mem_wr = 1; d_addr = 16'h0200;
      #1;
      checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0200) begin failures++; $display("FAIL proto_both_fwd: rd=%b wr=%b addr=%h expected 1 1 0200", mem_rd, mem_wr, mem_addr); end
      tick();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL proto_both_err: err=%b expected 1", err); end
      d_mem_rd = 0; d_mem_wr = 0;
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL proto_err_one_cycle: err=%b expected 0", err); end
      d_req = 0; d_mem_wr = 1;
      #1;
      checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL proto_drop_fwd: wr=%b expected 1", mem_wr); end
      tick();
      checks++; if (err !== 1'b1 || mem_wr !== 1'b0) begin failures++; $display("FAIL proto_drop_err: err=%b wr=%b expected 1 0", err, mem_wr); end
      d_mem_wr = 0;
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL proto_drop_clear: err=%b expected 0", err); end
   endtask

   task automatic test_async_reset();
      do_reset();
      d_req = 1; d_mem_rd = 1; d_mem_wr = 1;
      tick(); tick();
      checks++; if (d_gnt !== 1'b1 || mem_wr !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL arst_pre: gnt=%b wr=%b err=%b expected 1 1 1", d_gnt, mem_wr, err); end
      #2;
      rst = 1;
      #1;
      checks++; if (d_gnt !== 1'b0 || mem_wr !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL arst_drop: gnt=%b wr=%b err=%b expected 0 0 0", d_gnt, mem_wr, err); end
      #1;
      rst = 0;
      model_reset();
      d_mem_rd = 0; d_mem_wr = 0;
      #1;
      checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL arst_release: d_gnt=%b expected 0", d_gnt); end
      tick();
      checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL arst_regrant: d_gnt=%b expected 1", d_gnt); end
      d_req = 0;
      tick(); tick();
   endtask

   task automatic test_random();
      logic          er, ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) i_req = ~i_req;
         if ($urandom_range(0, 3) == 0) d_req = ~d_req;
         i_mem_rd  = ($urandom_range(0, 3) == 0);
         i_mem_wr  = ($urandom_range(0, 4) == 0);
         d_mem_rd  = ($urandom_range(0, 3) == 0);
         d_mem_wr  = ($urandom_range(0, 4) == 0);
         i_addr    = 16'($urandom);
         i_data_in = 16'($urandom);
         d_addr    = 16'($urandom);
         d_data_in = 16'($urandom);
         busy      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         #1;
         er = 0; ew = 0; ea = '0; ed = '0;
         if (m_owner == 1) begin er = i_mem_rd; ew = i_mem_wr; ea = i_addr; ed = i_data_in; end
         else if (m_owner == 2) begin er = d_mem_rd; ew = d_mem_wr; ea = d_addr; ed = d_data_in; end
         checks++; if ({i_gnt, d_gnt} !== {m_owner == 1, m_owner == 2}) begin failures++; $display("FAIL rand_gnt cyc %0d: i/d=%b%b expected owner %0d", n, i_gnt, d_gnt, m_owner); end
         checks++; if ({mem_rd, mem_wr, mem_addr, mem_data_in} !== {er, ew, ea, ed}) begin failures++; $display("FAIL rand_mem cyc %0d: rd=%b wr=%b a=%h d=%h expected %b %b %h %h", n, mem_rd, mem_wr, mem_addr, mem_data_in, er, ew, ea, ed); end
         checks++; if (i_gnt === 1'b1 && d_gnt === 1'b1) begin failures++; $display("FAIL rand_exclusive cyc %0d: both grants 1 expected at most one", n); end
         tick();
         if (m_err_known) begin
            checks++; if (err !== m_err) begin failures++; $display("FAIL rand_err cyc %0d: err=%b expected %b", n, err, m_err); end
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      model_reset();
      test_reset();
      test_lone_d();
      test_simultaneous();
      test_starvation();
      test_handoff();
      test_proto_err();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single four-bank main memory between the instruction-cache controller (I port) and the data-cache controller (D port).
- Grants one requester at a time, for an entire fill or writeback burst.
- Muxes the granted requester's rd/wr/addr/data onto the memory.
- Waits for all banks to go idle before handing ownership to the other requester.
- Sits between the two cache controllers and the four-bank memory. Each controller treats "no grant" as an extra stall.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_D_WINS, 3, maximum consecutive D grants while I is waiting before I is forced in (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  I controller wants memory; held high for the whole burst
- i_mem_rd  in  1  I read strobe
- i_mem_wr  in  1  I write strobe
- i_addr  in  ADDR_W  I address
- i_data_in  in  DATA_W  I write data
- d_req  in  1  D controller wants memory; held high for the whole burst
- d_mem_rd  in  1  D read strobe
- d_mem_wr  in  1  D write strobe
- d_addr  in  ADDR_W  D address
- d_data_in  in  DATA_W  D write data
- busy  in  4  per-bank busy from main memory
- i_gnt  out  1  I owns memory this cycle
- d_gnt  out  1  D owns memory this cycle
- mem_rd  out  1  read to memory
- mem_wr  out  1  write to memory
- mem_addr  out  ADDR_W  address to memory
- mem_data_in  out  DATA_W  write data to memory
- err  out  1  one-cycle protocol-error pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. During and immediately on reset, all outputs are 0. State returns to IDLE and the starvation counter clears.
- States: IDLE, GNT_I, GNT_D, DRAIN. The state is registered; i_gnt and d_gnt are decoded from state only (Moore outputs).
- IDLE:
  - No request: stay in IDLE.
  - Only i_req: go to GNT_I.
  - Only d_req: go to GNT_D.
  - Both requests: go to GNT_D, unless starve_cnt == MAX_D_WINS, in which case go to GNT_I.
  - Latency: grant is asserted exactly 1 cycle after req is first sampled high, when no other owner exists.
- GNT_I / GNT_D:
  - The matching gnt is 1.
  - mem_rd, mem_wr, mem_addr and mem_data_in combinationally follow the owner's inputs.
  - Leave when the owner's req is sampled low; next state is DRAIN.
  - The owner may not be preempted. Holding req indefinitely keeps the grant.
- DRAIN:
  - Both gnt are 0; memory outputs are 0.
  - Stay while |busy; go to IDLE when busy == 4'b0000.
  - Minimum 1 cycle, so the minimum switch gap is 2 cycles: DRAIN, then IDLE, then the new grant.
- Memory outputs in any state other than GNT_I/GNT_D: mem_rd = mem_wr = 0; addr and data = 0.
- Starvation counter (4 bits):
  - Increments on each IDLE->GNT_D transition taken while i_req = 1.
  - Clears on every IDLE->GNT_I transition.
  - Saturates at MAX_D_WINS.
- err pulses for one cycle, registered (visible the cycle after the violation), for any of:
  - a non-owner asserts its mem_rd or mem_wr (the strobe is ignored, never forwarded);
  - the owner asserts rd and wr together (forwarded as-is, flagged);
  - the owner drops req in the same cycle it drives a strobe (the strobe is still forwarded that cycle).
- A req that falls before its grant arrives is legal. Example: req high 1 cycle in IDLE, low in the next cycle. Sequence is GNT_x for 1 cycle, then DRAIN.
- Reset mid-burst: the grant drops asynchronously. The memory strobes go to 0 the same instant.

Test Plan:
- Lone D: d_req = 1 at cycle 0 with d_mem_rd, d_addr = 16'h0040 → d_gnt = 1 at cycle 1, mem_rd = 1, mem_addr = 16'h0040. Drop d_req at cycle 5 with busy = 4'b0010 for 2 cycles → DRAIN for 2 cycles, IDLE, d_gnt = 0 from cycle 6.
- Simultaneous request: i_req = d_req = 1 from IDLE with starve_cnt = 0 → d_gnt = 1. i_gnt stays 0 and i_mem_rd is not forwarded. i_mem_rd = 1 during the D grant → err = 1 one cycle later.
- Starvation: i_req held high; d_req re-asserted after each DRAIN → 3 D grants, then the 4th grant goes to I even with d_req = 1. starve_cnt returns to 0.
- Handoff: owner I drops req while D is waiting and busy = 4'b0000 → DRAIN 1 cycle, IDLE 1 cycle, d_gnt = 1. i_gnt and d_gnt are never both 1.
- Async reset: rst pulsed mid-GNT_D between clock edges → d_gnt, mem_wr and err go to 0 before the next edge. After release, d_req = 1 gives d_gnt 1 cycle later.
- Protocol error: owner drives mem_rd = mem_wr = 1 together → both forwarded and err pulses exactly 1 cycle.
